axis_pixel_packer: RTL and testbench

- Upstream neighbour of the depthwise stage. Accepts a narrow AXI-Stream from the DMA and packs consecutive beats into one wide pixel word of CIN*DATA_W bits.
- The packed pixel word feeds the depthwise layer's s_axis port directly.
- Tracks frame position against tlast, pulses an interrupt at frame end, and pulses an error on tlast mismatch.

---
 rtl/axis_pixel_packer_if.sv | 12 +
 rtl/axis_pixel_packer.sv | 127 ++++++++++++
 tb/tb_axis_pixel_packer.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pixel_packer_if.sv
// AXI-Stream bundle used for both the narrow DMA beat side and the wide pixel side of the packer.
interface axis_pixel_packer_if #(
   parameter int W = 64
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;
   logic         tlast;

   modport master (output tdata, output tvalid, input tready, output tlast);
   modport slave  (input tdata, input tvalid, output tready, input tlast);
endinterface

// File: rtl/axis_pixel_packer.sv
// Packs BEATS narrow AXI-Stream beats into one CIN*DATA_W pixel word, tracks frame position
// against tlast, and flags frame completion and tlast mismatches.
module axis_pixel_packer #(
   parameter int DATA_W     = 8,
   parameter int CIN        = 128,
   parameter int BUS_W      = 64,
   parameter int IMG_WIDTH  = 224,
   parameter int IMG_HEIGHT = 224
) (
   input  logic                clk,
   input  logic                reset,
   axis_pixel_packer_if.slave  s_axis,
   axis_pixel_packer_if.master m_axis,
   output logic                o_intr,
   output logic                o_err_tlast
);
   localparam int PIX_W     = CIN * DATA_W;
   localparam int BEATS     = PIX_W / BUS_W;
   localparam int ASM_W     = PIX_W - BUS_W;
   localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
   localparam int BEAT_CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PIX_CW    = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
   localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);
   localparam logic [PIX_CW-1:0]  LAST_PIX  = PIX_CW'(FRAME_PIX - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_WAIT_OUT
   } state_t;

   state_t             r_state;
   logic [BEAT_CW-1:0] r_beat_cnt;
   logic [PIX_CW-1:0]  r_pix_cnt;
   logic [ASM_W-1:0]   r_asm;
   logic [PIX_W-1:0]   r_out_data;
   logic               r_out_vld;
   logic               r_out_tag;
   logic               r_err;

   logic w_last_beat;
   logic w_frame_end;
   logic w_out_vld;
   logic w_out_hs;
   logic w_out_free;
   logic w_s_ready;
   logic w_in_hs;
   logic w_early;

   assign w_last_beat = (r_beat_cnt == LAST_BEAT);
   assign w_frame_end = w_last_beat && (r_pix_cnt == LAST_PIX);
   // Masking valid during reset keeps a stale pixel from handshaking in the reset cycle.
   assign w_out_vld   = r_out_vld && !reset;
   assign w_out_hs    = w_out_vld && m_axis.tready;
   assign w_out_free  = !r_out_vld || m_axis.tready;
   assign w_s_ready   = !w_last_beat || w_out_free;
   assign w_in_hs     = s_axis.tvalid && w_s_ready;
   assign w_early     = w_in_hs && s_axis.tlast && !w_frame_end;

   assign s_axis.tready = w_s_ready;
   assign m_axis.tvalid = w_out_vld;
   assign m_axis.tdata  = r_out_data;
   assign m_axis.tlast  = r_out_tag;
   assign o_intr        = w_out_hs && r_out_tag;
   assign o_err_tlast   = r_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_beat_cnt <= '0;
         r_pix_cnt  <= '0;
         r_asm      <= '0;
         r_out_data <= '0;
         r_out_vld  <= 1'b0;
         r_out_tag  <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_in_hs && (s_axis.tlast != w_frame_end);

         // Output stage: drain and refill may happen in the same cycle.
         if (w_out_hs)
            r_out_vld <= 1'b0;
         if (w_in_hs && w_last_beat) begin
            r_out_vld  <= 1'b1;
            r_out_data <= {s_axis.tdata, r_asm};
            r_out_tag  <= w_frame_end;
         end

         if (w_early && !w_last_beat) begin
            r_asm <= '0;
         end else if (w_in_hs && !w_last_beat) begin
            for (int k = 0; k < BEATS - 1; k++)
               if (r_beat_cnt == BEAT_CW'(k))
                  r_asm[k*BUS_W +: BUS_W] <= s_axis.tdata;
         end

         if (w_in_hs) begin
            if (s_axis.tlast || w_last_beat)
               r_beat_cnt <= '0;
            else
               r_beat_cnt <= r_beat_cnt + 1'b1;
            if (s_axis.tlast || w_frame_end)
               r_pix_cnt <= '0;
            else if (w_last_beat)
               r_pix_cnt <= r_pix_cnt + 1'b1;
         end

         if (w_early || (w_in_hs && w_frame_end)) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE:
                  if (w_in_hs)
                     r_state <= S_FILL;
               S_FILL:
                  if (w_last_beat && s_axis.tvalid && !w_s_ready)
                     r_state <= S_WAIT_OUT;
               S_WAIT_OUT:
                  if (w_out_free)
                     r_state <= S_FILL;
               default:
                  r_state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_axis_pixel_packer.sv
// Randomized scenario bench for axis_pixel_packer, checked against a frame-position reference model.
`timescale 1ns/1ps
module tb_axis_pixel_packer;
   localparam int DATA_W      = 8;
   localparam int CIN         = 8;
   localparam int BUS_W       = 16;
   localparam int IMG_WIDTH   = 2;
   localparam int IMG_HEIGHT  = 2;
   localparam int PIX_W       = CIN * DATA_W;
   localparam int BEATS       = PIX_W / BUS_W;
   localparam int FRAME_BEATS = IMG_WIDTH * IMG_HEIGHT * BEATS;

   logic clk = 1'b0;
   logic reset;
   logic o_intr;
   logic o_err_tlast;

   always #5 clk = ~clk;

   axis_pixel_packer_if #(.W(BUS_W)) s_if ();
   axis_pixel_packer_if #(.W(PIX_W)) m_if ();

   axis_pixel_packer #(
      .DATA_W(DATA_W), .CIN(CIN), .BUS_W(BUS_W),
      .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .s_axis(s_if.slave),
      .m_axis(m_if.master),
      .o_intr(o_intr),
      .o_err_tlast(o_err_tlast)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [BUS_W-1:0] stim_data[$];
   bit               stim_last[$];
   logic [PIX_W-1:0] exp_data[$];
   bit               exp_tag[$];
   int               exp_err;
   int               exp_intr;

   // Output collector: records what the DUT emits; scenario tasks do the judging.
   logic [PIX_W-1:0] obs_data[$];
   bit               obs_tag[$];
   int               err_cnt    = 0;
   int               intr_cnt   = 0;
   int               stray_intr = 0;
   int               stab_viol  = 0;
   bit               prev_stall = 1'b0;
   logic [PIX_W-1:0] prev_data  = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data))
               stab_viol++;
            if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
               obs_data.push_back(m_if.tdata);
               obs_tag.push_back(o_intr === 1'b1);
            end else if (o_intr === 1'b1) begin
               stray_intr++;
            end
            if (o_intr === 1'b1)      intr_cnt++;
            if (o_err_tlast === 1'b1) err_cnt++;
            prev_stall = (m_if.tvalid === 1'b1) && (m_if.tready !== 1'b1);
            prev_data  = m_if.tdata;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog");
   end

   // Reference model: walks the beat list by position within the frame.
   function automatic void build_expect();
      int pos = 0;
      logic [PIX_W-1:0] word = '0;
      exp_data.delete();
      exp_tag.delete();
      exp_err  = 0;
      exp_intr = 0;
      foreach (stim_data[i]) begin
         word = word | (PIX_W'(stim_data[i]) << ((pos % BEATS) * BUS_W));
         if (pos % BEATS == BEATS - 1) begin
            exp_data.push_back(word);
            exp_tag.push_back(pos == FRAME_BEATS - 1);
            if (pos == FRAME_BEATS - 1) exp_intr++;
            word = '0;
         end
         if (stim_last[i] != (pos == FRAME_BEATS - 1)) exp_err++;
         if (stim_last[i] || pos == FRAME_BEATS - 1) begin
            pos  = 0;
            word = '0;
         end else begin
            pos++;
         end
      end
   endfunction

   task automatic add_beats(input int n, input int last_at);
      for (int i = 1; i <= n; i++) begin
         stim_data.push_back(BUS_W'($urandom));
         stim_last.push_back(i == last_at);
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tdata  = '0;
      m_if.tready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic drive_beat(input logic [BUS_W-1:0] d, input bit l, output int waits);
      bit rdy;
      bit ok;
      waits = 0;
      ok    = 1'b0;
      s_if.tdata  = d;
      s_if.tlast  = l;
      s_if.tvalid = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         rdy = (s_if.tready === 1'b1);
         @(posedge clk);
         #1;
         if (rdy) ok = 1'b1;
         else     waits++;
      end
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL beat_accept: not accepted after %0d cycles, required within 200", waits);
      end
   endtask

   task automatic run_stream(input int gap_pct, input int rdy_pct, input int need, output int waits);
      bit done;
      int w;
      done  = 1'b0;
      waits = 0;
      fork
         begin
            foreach (stim_data[i]) begin
               if ($urandom_range(99) < gap_pct) begin
                  s_if.tvalid = 1'b0;
                  repeat ($urandom_range(3, 1)) begin
                     @(posedge clk);
                     #1;
                  end
               end
               drive_beat(stim_data[i], stim_last[i], w);
               waits += w;
            end
            for (int t = 0; t < 400 && obs_data.size() < need; t++) @(posedge clk);
            repeat (2) @(posedge clk);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               m_if.tready = ($urandom_range(99) < rdy_pct);
            end
         end
      join
      m_if.tready = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_tests++;
      if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_if.tvalid); end
      n_tests++;
      if (m_if.tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_if.tdata); end
      n_tests++;
      if (o_intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %b want 0", o_intr); end
      n_tests++;
      if (o_err_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", o_err_tlast); end
      n_tests++;
      if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b want 1", s_if.tready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic_pack();
      int w;
      do_reset();
      stim_data.delete();
      stim_last.delete();
      stim_data = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
      stim_last = '{0, 0, 0, 0};
      build_expect();
      for (int i = 0; i < BEATS; i++) begin
         n_tests++;
         if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: beat %0d got %b want 0", i, m_if.tvalid); end
         drive_beat(stim_data[i], stim_last[i], w);
      end
      n_tests++;
      if (m_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b want 1", m_if.tvalid); end
      n_tests++;
      if (m_if.tdata !== 64'h0706050403020100) begin n_fail++; $display("FAIL basic_data: got %h want 0706050403020100", m_if.tdata); end
      n_tests++;
      if (m_if.tdata !== exp_data[0]) begin n_fail++; $display("FAIL basic_model: got %h want %h", m_if.tdata, exp_data[0]); end
      @(posedge clk);
      #1;
      n_tests++;
      if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", m_if.tvalid); end
   endtask

   task automatic test_back_pressure();
      int w;
      int w7;
      int base;
      int sb;
      do_reset();
      stim_data.delete();
      stim_last.delete();
      add_beats(2 * BEATS, 0);
      build_expect();
      base = obs_data.size();
      sb   = stab_viol;
      m_if.tready = 1'b0;
      for (int i = 0; i < 2 * BEATS - 1; i++) begin
         drive_beat(stim_data[i], stim_last[i], w);
         n_tests++;
         if (w !== 0) begin n_fail++; $display("FAIL bp_accept: beat %0d waited %0d want 0", i, w); end
      end
      fork
         drive_beat(stim_data[2*BEATS-1], stim_last[2*BEATS-1], w7);
         begin
            repeat (3) @(negedge clk);
            n_tests++;
            if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready: got %b want 0", s_if.tready); end
            n_tests++;
            if (m_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b want 1", m_if.tvalid); end
            n_tests++;
            if (m_if.tdata !== exp_data[0]) begin n_fail++; $display("FAIL bp_hold_data: got %h want %h", m_if.tdata, exp_data[0]); end
            @(posedge clk);
            #1 m_if.tready = 1'b1;
            @(negedge clk);
            n_tests++;
            if (s_if.tready !== 1'b1 || m_if.tvalid !== 1'b1) begin
               n_fail++;
               $display("FAIL bp_drain_refill: tready %b tvalid %b want 1 1", s_if.tready, m_if.tvalid);
            end
         end
      join
      for (int t = 0; t < 50 && obs_data.size() < base + exp_data.size(); t++) @(posedge clk);
      #1;
      n_tests++;
      if (obs_data.size() - base !== exp_data.size()) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", obs_data.size() - base, exp_data.size()); end
      for (int i = 0; i < exp_data.size(); i++) begin
         if (base + i < obs_data.size()) begin
            n_tests++;
            if (obs_data[base+i] !== exp_data[i]) begin n_fail++; $display("FAIL bp_pixel%0d: got %h want %h", i, obs_data[base+i], exp_data[i]); end
         end
      end
      n_tests++;
      if (stab_viol - sb !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d violations want 0", stab_viol - sb); end
   endtask

   task automatic test_full_frame();
      int w;
      int base;
      int eb;
      int ib;
      int sb;
      int xb;
      do_reset();
      stim_data.delete();
      stim_last.delete();
      add_beats(FRAME_BEATS, FRAME_BEATS);
      build_expect();
      base = obs_data.size(); eb = err_cnt; ib = intr_cnt; sb = stab_viol; xb = stray_intr;
      run_stream(30, 50, base + exp_data.size(), w);
      n_tests++;
      if (obs_data.size() - base !== exp_data.size()) begin n_fail++; $display("FAIL frame_count: got %0d want %0d", obs_data.size() - base, exp_data.size()); end
      for (int i = 0; i < exp_data.size(); i++) begin
         if (base + i < obs_data.size()) begin
            n_tests++;
            if (obs_data[base+i] !== exp_data[i]) begin n_fail++; $display("FAIL frame_pixel%0d: got %h want %h", i, obs_data[base+i], exp_data[i]); end
            n_tests++;
            if (obs_tag[base+i] !== exp_tag[i]) begin n_fail++; $display("FAIL frame_intr%0d: got %b want %b", i, obs_tag[base+i], exp_tag[i]); end
         end
      end
      n_tests++;
      if (intr_cnt - ib !== exp_intr) begin n_fail++; $display("FAIL frame_intr_count: got %0d want %0d", intr_cnt - ib, exp_intr); end
      n_tests++;
      if (err_cnt - eb !== exp_err) begin n_fail++; $display("FAIL frame_err: got %0d want %0d", err_cnt - eb, exp_err); end
      n_tests++;
      if (stray_intr - xb !== 0 || stab_viol - sb !== 0) begin
         n_fail++;
         $display("FAIL frame_stray: stray intr %0d unstable %0d want 0 0", stray_intr - xb, stab_viol - sb);
      end
   endtask

   task automatic test_early_tlast();
      int w;
      int base;
      int eb;
      int ib;
      do_reset();
      stim_data.delete();
      stim_last.delete();
      add_beats(BEATS + 2, BEATS + 2);
      add_beats(FRAME_BEATS, FRAME_BEATS);
      build_expect();
      base = obs_data.size(); eb = err_cnt; ib = intr_cnt;
      run_stream(20, 70, base + exp_data.size(), w);
      n_tests++;
      if (obs_data.size() - base !== exp_data.size()) begin n_fail++; $display("FAIL early_count: got %0d want %0d", obs_data.size() - base, exp_data.size()); end
      for (int i = 0; i < exp_data.size(); i++) begin
         if (base + i < obs_data.size()) begin
            n_tests++;
            if (obs_data[base+i] !== exp_data[i] || obs_tag[base+i] !== exp_tag[i]) begin
               n_fail++;
               $display("FAIL early_pixel%0d: got %h/%b want %h/%b", i, obs_data[base+i], obs_tag[base+i], exp_data[i], exp_tag[i]);
            end
         end
      end
      n_tests++;
      if (err_cnt - eb !== exp_err) begin n_fail++; $display("FAIL early_err: got %0d want %0d", err_cnt - eb, exp_err); end
      n_tests++;
      if (intr_cnt - ib !== exp_intr) begin n_fail++; $display("FAIL early_intr: got %0d want %0d", intr_cnt - ib, exp_intr); end
   endtask

   task automatic test_missing_tlast();
      int w;
      int base;
      int eb;
      int ib;
      do_reset();
      stim_data.delete();
      stim_last.delete();
      add_beats(FRAME_BEATS, 0);
      add_beats(FRAME_BEATS, FRAME_BEATS);
      build_expect();
      base = obs_data.size(); eb = err_cnt; ib = intr_cnt;
      run_stream(20, 60, base + exp_data.size(), w);
      n_tests++;
      if (obs_data.size() - base !== exp_data.size()) begin n_fail++; $display("FAIL missing_count: got %0d want %0d", obs_data.size() - base, exp_data.size()); end
      for (int i = 0; i < exp_data.size(); i++) begin
         if (base + i < obs_data.size()) begin
            n_tests++;
            if (obs_data[base+i] !== exp_data[i] || obs_tag[base+i] !== exp_tag[i]) begin
               n_fail++;
               $display("FAIL missing_pixel%0d: got %h/%b want %h/%b", i, obs_data[base+i], obs_tag[base+i], exp_data[i], exp_tag[i]);
            end
         end
      end
      n_tests++;
      if (err_cnt - eb !== exp_err) begin n_fail++; $display("FAIL missing_err: got %0d want %0d", err_cnt - eb, exp_err); end
      n_tests++;
      if (intr_cnt - ib !== exp_intr) begin n_fail++; $display("FAIL missing_intr: got %0d want %0d", intr_cnt - ib, exp_intr); end
   endtask

   task automatic test_back_to_back();
      int w;
      int base;
      int ib;
      do_reset();
      stim_data.delete();
      stim_last.delete();
      add_beats(FRAME_BEATS, FRAME_BEATS);
      add_beats(FRAME_BEATS, FRAME_BEATS);
      build_expect();
      base = obs_data.size(); ib = intr_cnt;
      run_stream(0, 100, base + exp_data.size(), w);
      n_tests++;
      if (w !== 0) begin n_fail++; $display("FAIL b2b_bubbles: got %0d stall cycles want 0", w); end
      n_tests++;
      if (obs_data.size() - base !== exp_data.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", obs_data.size() - base, exp_data.size()); end
      for (int i = 0; i < exp_data.size(); i++) begin
         if (base + i < obs_data.size()) begin
            n_tests++;
            if (obs_data[base+i] !== exp_data[i] || obs_tag[base+i] !== exp_tag[i]) begin
               n_fail++;
               $display("FAIL b2b_pixel%0d: got %h/%b want %h/%b", i, obs_data[base+i], obs_tag[base+i], exp_data[i], exp_tag[i]);
            end
         end
      end
      n_tests++;
      if (intr_cnt - ib !== exp_intr) begin n_fail++; $display("FAIL b2b_intr: got %0d want %0d", intr_cnt - ib, exp_intr); end
   endtask

   task automatic test_reset_mid();
      int w;
      int base;
      int eb;
      int ib;
      do_reset();
      for (int i = 0; i < 2 * BEATS; i++) drive_beat(BUS_W'($urandom), 1'b0, w);
      m_if.tready = 1'b0;
      drive_beat(BUS_W'($urandom), 1'b0, w);
      n_tests++;
      if (m_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL rmid_pending: got %b want 1", m_if.tvalid); end
      reset = 1'b1;
      m_if.tready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_in_reset: got %b want 0", m_if.tvalid); end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (m_if.tvalid !== 1'b0 || m_if.tdata !== '0 || s_if.tready !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_after: tvalid %b tdata %h tready %b want 0 0 1", m_if.tvalid, m_if.tdata, s_if.tready);
      end
      @(posedge clk);
      #1;
      stim_data.delete();
      stim_last.delete();
      add_beats(FRAME_BEATS, FRAME_BEATS);
      build_expect();
      base = obs_data.size(); eb = err_cnt; ib = intr_cnt;
      run_stream(25, 60, base + exp_data.size(), w);
      n_tests++;
      if (obs_data.size() - base !== exp_data.size()) begin n_fail++; $display("FAIL rmid_count: got %0d want %0d", obs_data.size() - base, exp_data.size()); end
      for (int i = 0; i < exp_data.size(); i++) begin
         if (base + i < obs_data.size()) begin
            n_tests++;
            if (obs_data[base+i] !== exp_data[i] || obs_tag[base+i] !== exp_tag[i]) begin
               n_fail++;
               $display("FAIL rmid_pixel%0d: got %h/%b want %h/%b", i, obs_data[base+i], obs_tag[base+i], exp_data[i], exp_tag[i]);
            end
         end
      end
      n_tests++;
      if (intr_cnt - ib !== exp_intr || err_cnt - eb !== exp_err) begin
         n_fail++;
         $display("FAIL rmid_flags: intr %0d err %0d want %0d %0d", intr_cnt - ib, err_cnt - eb, exp_intr, exp_err);
      end
   endtask

   initial begin
      reset       = 1'b1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tdata  = '0;
      m_if.tready = 1'b1;
      test_reset();
      test_basic_pack();
      test_back_pressure();
      test_full_frame();
      test_early_tlast();
      test_missing_tlast();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
